mc_control_fsm: RTL and testbench

//  Main control FSM for the multicycle MIPS core; sits directly upstream of the ALU.

---
 rtl/mc_control_fsm.sv | 225 ++++++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// Main control FSM for the multicycle MIPS core: sequences fetch/decode/execute/
// memory/writeback and drives ALU op, operand selects and datapath enables.
module mc_control_fsm #(
  parameter int unsigned OP_W    = 6,
  parameter int unsigned FUNCT_W = 6,
  parameter int unsigned CTRL_W  = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [OP_W-1:0]    i_opcode,
  input  logic [FUNCT_W-1:0] i_funct,
  input  logic               i_zf,
  input  logic               i_mem_ready,
  output logic               o_mem_req,
  output logic               o_mem_write,
  output logic               o_iord,
  output logic               o_ir_write,
  output logic               o_pc_en,
  output logic [1:0]         o_pc_src,
  output logic               o_alusrca,
  output logic [1:0]         o_alusrcb,
  output logic [CTRL_W-1:0]  o_alu_control,
  output logic               o_reg_write,
  output logic               o_reg_dst,
  output logic               o_mem_to_reg,
  output logic               o_illegal
);

  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_REX, S_RWB, S_BEQ, S_ADDIEX, S_ADDIWB, S_JMP
  } state_e;

  localparam logic [CTRL_W-1:0] ALU_AND = CTRL_W'(0);
  localparam logic [CTRL_W-1:0] ALU_OR  = CTRL_W'(1);
  localparam logic [CTRL_W-1:0] ALU_ADD = CTRL_W'(2);
  localparam logic [CTRL_W-1:0] ALU_SUB = CTRL_W'(3);
  localparam logic [CTRL_W-1:0] ALU_SLT = CTRL_W'(4);
  localparam logic [CTRL_W-1:0] ALU_NOR = CTRL_W'(5);

  localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);

  state_e              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_write_q, mem_write_d;
  logic                iord_q, iord_d;
  logic [1:0]          pc_src_q, pc_src_d;
  logic                alusrca_q, alusrca_d;
  logic [1:0]          alusrcb_q, alusrcb_d;
  logic [CTRL_W-1:0]   alu_control_q, alu_control_d;
  logic                reg_write_q, reg_write_d;
  logic                reg_dst_q, reg_dst_d;
  logic                mem_to_reg_q, mem_to_reg_d;
  logic                pcwrite_q, pcwrite_d;
  logic                branch_q, branch_d;

  logic [CTRL_W-1:0]   rex_ctrl;
  logic                rex_valid;
  logic                op_valid;

  always_comb begin
    rex_valid = 1'b1;
    rex_ctrl  = ALU_AND;
    case (i_funct)
      FUNCT_W'(6'b100000): rex_ctrl = ALU_ADD;
      FUNCT_W'(6'b100010): rex_ctrl = ALU_SUB;
      FUNCT_W'(6'b100100): rex_ctrl = ALU_AND;
      FUNCT_W'(6'b100101): rex_ctrl = ALU_OR;
      FUNCT_W'(6'b101010): rex_ctrl = ALU_SLT;
      FUNCT_W'(6'b100111): rex_ctrl = ALU_NOR;
      default:             rex_valid = 1'b0;
    endcase
  end

  always_comb begin
    op_valid = (i_opcode == OP_LW) || (i_opcode == OP_SW) || (i_opcode == OP_R) ||
               (i_opcode == OP_BEQ) || (i_opcode == OP_ADDI) || (i_opcode == OP_J);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:    state_d = S_FETCH;
      S_FETCH:  if (i_mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (i_opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_REX;
          OP_BEQ:       state_d = S_BEQ;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (i_opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (i_mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (i_mem_ready) state_d = S_FETCH;
      S_REX:    state_d = rex_valid ? S_RWB : S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_RWB, S_BEQ, S_ADDIWB, S_JMP: state_d = S_FETCH;
      default:  state_d = S_RST;
    endcase
  end

  // Moore outputs are decoded from the next state and registered, so they
  // line up with the state they belong to without a combinational decode.
  always_comb begin
    mem_req_d     = 1'b0;
    mem_write_d   = 1'b0;
    iord_d        = 1'b0;
    pc_src_d      = 2'b00;
    alusrca_d     = 1'b0;
    alusrcb_d     = 2'b00;
    alu_control_d = ALU_AND;
    reg_write_d   = 1'b0;
    reg_dst_d     = 1'b0;
    mem_to_reg_d  = 1'b0;
    pcwrite_d     = 1'b0;
    branch_d      = 1'b0;
    case (state_d)
      S_FETCH: begin
        mem_req_d     = 1'b1;
        alusrcb_d     = 2'b01;
        alu_control_d = ALU_ADD;
      end
      S_DECODE: begin
        alusrcb_d     = 2'b11;
        alu_control_d = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        alusrca_d     = 1'b1;
        alusrcb_d     = 2'b10;
        alu_control_d = ALU_ADD;
      end
      S_MEMRD: begin
        mem_req_d = 1'b1;
        iord_d    = 1'b1;
      end
      S_MEMWB: begin
        reg_write_d  = 1'b1;
        mem_to_reg_d = 1'b1;
      end
      S_MEMWR: begin
        mem_req_d   = 1'b1;
        mem_write_d = 1'b1;
        iord_d      = 1'b1;
      end
      S_REX: begin
        alusrca_d     = 1'b1;
        alu_control_d = rex_ctrl;
      end
      S_RWB: begin
        reg_write_d   = 1'b1;
        reg_dst_d     = 1'b1;
        alu_control_d = alu_control_q;
      end
      S_BEQ: begin
        alusrca_d     = 1'b1;
        alu_control_d = ALU_SUB;
        pc_src_d      = 2'b01;
        branch_d      = 1'b1;
      end
      S_ADDIWB: reg_write_d = 1'b1;
      S_JMP: begin
        pc_src_d  = 2'b10;
        pcwrite_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= S_RST;
      mem_req_q     <= 1'b0;
      mem_write_q   <= 1'b0;
      iord_q        <= 1'b0;
      pc_src_q      <= '0;
      alusrca_q     <= 1'b0;
      alusrcb_q     <= '0;
      alu_control_q <= '0;
      reg_write_q   <= 1'b0;
      reg_dst_q     <= 1'b0;
      mem_to_reg_q  <= 1'b0;
      pcwrite_q     <= 1'b0;
      branch_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_write_q   <= mem_write_d;
      iord_q        <= iord_d;
      pc_src_q      <= pc_src_d;
      alusrca_q     <= alusrca_d;
      alusrcb_q     <= alusrcb_d;
      alu_control_q <= alu_control_d;
      reg_write_q   <= reg_write_d;
      reg_dst_q     <= reg_dst_d;
      mem_to_reg_q  <= mem_to_reg_d;
      pcwrite_q     <= pcwrite_d;
      branch_q      <= branch_d;
    end
  end

  assign o_mem_req     = mem_req_q;
  assign o_mem_write   = mem_write_q;
  assign o_iord        = iord_q;
  assign o_pc_src      = pc_src_q;
  assign o_alusrca     = alusrca_q;
  assign o_alusrcb     = alusrcb_q;
  assign o_alu_control = alu_control_q;
  assign o_reg_write   = reg_write_q;
  assign o_reg_dst     = reg_dst_q;
  assign o_mem_to_reg  = mem_to_reg_q;

  // Strobes that depend on same-cycle inputs stay combinational.
  assign o_ir_write = (state_q == S_FETCH) && i_mem_ready;
  assign o_pc_en    = ((state_q == S_FETCH) && i_mem_ready) || pcwrite_q || (branch_q && i_zf);
  assign o_illegal  = ((state_q == S_DECODE) && !op_valid) || ((state_q == S_REX) && !rex_valid);

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: a per-state reference model pushes the
// expected output vector to a scoreboard queue, popped and compared each cycle.
module tb_mc_control_fsm;

  typedef enum int {
    RST, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REX, RWB, BEQ, ADDIEX, ADDIWB, JMP
  } st_e;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic [5:0] i_opcode;
  logic [5:0] i_funct;
  logic       i_zf;
  logic       i_mem_ready;
  logic       o_mem_req, o_mem_write, o_iord, o_ir_write, o_pc_en;
  logic [1:0] o_pc_src;
  logic       o_alusrca;
  logic [1:0] o_alusrcb;
  logic [3:0] o_alu_control;
  logic       o_reg_write, o_reg_dst, o_mem_to_reg, o_illegal;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [17:0] exp_q[$];

  localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B, OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_J = 6'h02, OP_BAD = 6'h3F;
  localparam logic [5:0] F_SUB = 6'h22, F_SLT = 6'h2A, F_BAD = 6'h01;

  mc_control_fsm #(.OP_W(6), .FUNCT_W(6), .CTRL_W(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_opcode(i_opcode), .i_funct(i_funct),
    .i_zf(i_zf), .i_mem_ready(i_mem_ready), .o_mem_req(o_mem_req),
    .o_mem_write(o_mem_write), .o_iord(o_iord), .o_ir_write(o_ir_write),
    .o_pc_en(o_pc_en), .o_pc_src(o_pc_src), .o_alusrca(o_alusrca),
    .o_alusrcb(o_alusrcb), .o_alu_control(o_alu_control), .o_reg_write(o_reg_write),
    .o_reg_dst(o_reg_dst), .o_mem_to_reg(o_mem_to_reg), .o_illegal(o_illegal)
  );

  always #5 i_clk = ~i_clk;

  // Vector: {req,wr,iord,irw,pcen,pcsrc[1:0],a,b[1:0],ctl[3:0],rw,rdst,m2r,ill}
  function automatic logic [17:0] model(input st_e st, input logic rdy, input logic zf,
                                        input logic [5:0] op, input logic [5:0] fn);
    logic req, wr, iord, irw, pcen, a, rw, rdst, m2r, ill, fok;
    logic [1:0] pcsrc, b;
    logic [3:0] ctl, fctl;
    {req, wr, iord, irw, pcen, a, rw, rdst, m2r, ill} = '0;
    pcsrc = '0; b = '0; ctl = '0;
    fok = 1'b1;
    case (fn)
      6'h20: fctl = 4'd2;
      6'h22: fctl = 4'd3;
      6'h24: fctl = 4'd0;
      6'h25: fctl = 4'd1;
      6'h2A: fctl = 4'd4;
      6'h27: fctl = 4'd5;
      default: begin fctl = 4'd0; fok = 1'b0; end
    endcase
    case (st)
      FETCH:  begin req = 1; b = 2'b01; ctl = 4'd2; irw = rdy; pcen = rdy; end
      DECODE: begin
        b = 2'b11; ctl = 4'd2;
        ill = !(op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J});
      end
      MEMADR, ADDIEX: begin a = 1; b = 2'b10; ctl = 4'd2; end
      MEMRD:  begin req = 1; iord = 1; end
      MEMWB:  begin rw = 1; m2r = 1; end
      MEMWR:  begin req = 1; wr = 1; iord = 1; end
      REX:    begin a = 1; ctl = fctl; ill = !fok; end
      RWB:    begin rw = 1; rdst = 1; ctl = fctl; end
      BEQ:    begin a = 1; ctl = 4'd3; pcsrc = 2'b01; pcen = zf; end
      ADDIWB: rw = 1;
      JMP:    begin pcsrc = 2'b10; pcen = 1; end
      default: ;
    endcase
    return {req, wr, iord, irw, pcen, pcsrc, a, b, ctl, rw, rdst, m2r, ill};
  endfunction

  task automatic step(input string tag, input st_e st, input logic rst, input logic rdy,
                      input logic zf, input logic [5:0] op, input logic [5:0] fn);
    logic [17:0] got, want;
    i_rst_n = rst; i_mem_ready = rdy; i_zf = zf; i_opcode = op; i_funct = fn;
    exp_q.push_back(model(st, rdy, zf, op, fn));
    #1;
    got = {o_mem_req, o_mem_write, o_iord, o_ir_write, o_pc_en, o_pc_src, o_alusrca,
           o_alusrcb, o_alu_control, o_reg_write, o_reg_dst, o_mem_to_reg, o_illegal};
    want = exp_q.pop_front();
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, got, want);
    end
    @(negedge i_clk);
  endtask

  initial begin
    i_rst_n = 1'b0; i_opcode = '0; i_funct = '0; i_zf = 1'b0; i_mem_ready = 1'b0;
    @(negedge i_clk);
    step("rst_hold0", RST, 0, 1, 1, OP_R, F_SUB);
    step("rst_hold1", RST, 0, 1, 1, OP_R, F_SUB);
    step("rst_rel",   RST, 1, 0, 0, OP_R, F_SUB);
    step("fetch_wait", FETCH, 1, 0, 0, OP_R, F_SUB);
    // R-type sub
    step("sub_fetch", FETCH, 1, 1, 0, OP_R, F_SUB);
    step("sub_dec",   DECODE, 1, 1, 0, OP_R, F_SUB);
    step("sub_rex",   REX, 1, 1, 0, OP_R, F_SUB);
    step("sub_rwb",   RWB, 1, 1, 0, OP_R, F_SUB);
    // lw with two wait cycles in MEMRD
    step("lw_fetch",  FETCH, 1, 1, 0, OP_LW, F_SUB);
    step("lw_dec",    DECODE, 1, 0, 0, OP_LW, F_SUB);
    step("lw_adr",    MEMADR, 1, 1, 0, OP_LW, F_SUB);
    step("lw_rd0",    MEMRD, 1, 0, 0, OP_LW, F_SUB);
    step("lw_rd1",    MEMRD, 1, 0, 0, OP_LW, F_SUB);
    step("lw_rd2",    MEMRD, 1, 1, 0, OP_LW, F_SUB);
    step("lw_wb",     MEMWB, 1, 1, 0, OP_LW, F_SUB);
    // beq taken / not taken
    step("beq1_fetch", FETCH, 1, 1, 1, OP_BEQ, F_SUB);
    step("beq1_dec",   DECODE, 1, 1, 1, OP_BEQ, F_SUB);
    step("beq1_ex",    BEQ, 1, 1, 1, OP_BEQ, F_SUB);
    step("beq0_fetch", FETCH, 1, 1, 0, OP_BEQ, F_SUB);
    step("beq0_dec",   DECODE, 1, 1, 0, OP_BEQ, F_SUB);
    step("beq0_ex",    BEQ, 1, 1, 0, OP_BEQ, F_SUB);
    // illegal opcode
    step("ill_fetch", FETCH, 1, 1, 0, OP_BAD, F_SUB);
    step("ill_dec",   DECODE, 1, 1, 0, OP_BAD, F_SUB);
    step("ill_next",  FETCH, 1, 0, 0, OP_BAD, F_SUB);
    // illegal funct
    step("ilf_fetch", FETCH, 1, 1, 0, OP_R, F_BAD);
    step("ilf_dec",   DECODE, 1, 1, 0, OP_R, F_BAD);
    step("ilf_rex",   REX, 1, 1, 0, OP_R, F_BAD);
    step("ilf_next",  FETCH, 1, 0, 0, OP_R, F_BAD);
    // slt, addi, j
    step("slt_fetch", FETCH, 1, 1, 0, OP_R, F_SLT);
    step("slt_dec",   DECODE, 1, 1, 0, OP_R, F_SLT);
    step("slt_rex",   REX, 1, 1, 0, OP_R, F_SLT);
    step("slt_rwb",   RWB, 1, 1, 0, OP_R, F_SLT);
    step("addi_fetch", FETCH, 1, 1, 0, OP_ADDI, F_SLT);
    step("addi_dec",   DECODE, 1, 1, 0, OP_ADDI, F_SLT);
    step("addi_ex",    ADDIEX, 1, 1, 0, OP_ADDI, F_SLT);
    step("addi_wb",    ADDIWB, 1, 1, 0, OP_ADDI, F_SLT);
    step("j_fetch", FETCH, 1, 1, 0, OP_J, F_SLT);
    step("j_dec",   DECODE, 1, 1, 0, OP_J, F_SLT);
    step("j_ex",    JMP, 1, 1, 0, OP_J, F_SLT);
    // sw completing normally
    step("sw_fetch", FETCH, 1, 1, 0, OP_SW, F_SUB);
    step("sw_dec",   DECODE, 1, 1, 0, OP_SW, F_SUB);
    step("sw_adr",   MEMADR, 1, 1, 0, OP_SW, F_SUB);
    step("sw_wr",    MEMWR, 1, 1, 0, OP_SW, F_SUB);
    // sw with reset during the write wait
    step("swr_fetch", FETCH, 1, 1, 0, OP_SW, F_SUB);
    step("swr_dec",   DECODE, 1, 1, 0, OP_SW, F_SUB);
    step("swr_adr",   MEMADR, 1, 1, 0, OP_SW, F_SUB);
    step("swr_wait",  MEMWR, 1, 0, 0, OP_SW, F_SUB);
    step("swr_rst",   RST, 0, 0, 0, OP_SW, F_SUB);
    step("swr_rel",   RST, 1, 0, 0, OP_SW, F_SUB);
    step("swr_fetch2", FETCH, 1, 0, 0, OP_SW, F_SUB);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
